// File: rtl/mem_stage.sv
// Memory stage of a five-stage pipeline: EX/MEM register, single-port data memory
// with combinational read, and the MEM/WB register feeding write-back and forwarding.
module mem_stage #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic [31:0] ex_alures,
  input  logic [31:0] ex_data,
  input  logic [4:0]  ex_rg,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic        ex_regwrite,
  input  logic        ex_memtoreg,
  output logic [31:0] mem_alures,
  output logic [4:0]  mem_rg,
  output logic        mem_regwrite,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rg,
  output logic        wb_regwrite
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] alures_r;
  logic [31:0] data_r;
  logic [4:0]  rg_r;
  logic        memread_r;
  logic        memwrite_r;
  logic        memtoreg_r;
  logic        regwrite_r;

  logic [31:0] wb_data_r;
  logic [4:0]  wb_rg_r;
  logic        wb_regwrite_r;

  logic [31:0] mem_array_r [DEPTH];

  logic [AW-1:0] addr_s;
  logic [31:0]   rdata_s;
  logic          unused_s;

  // Byte address to word index; upper bits drop so accesses wrap around the array.
  assign addr_s   = alures_r[AW+1:2];
  assign rdata_s  = mem_array_r[addr_s];
  // The latched load flag has no consumer: memtoreg alone selects the write-back source.
  assign unused_s = memread_r;

  // EX/MEM pipeline register; regwrite is qualified so r0 never looks like a destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      alures_r   <= 32'd0;
      data_r     <= 32'd0;
      rg_r       <= 5'd0;
      memread_r  <= 1'b0;
      memwrite_r <= 1'b0;
      memtoreg_r <= 1'b0;
      regwrite_r <= 1'b0;
    end else if (!freeze) begin
      alures_r   <= ex_alures;
      data_r     <= ex_data;
      rg_r       <= ex_rg;
      memread_r  <= ex_memread;
      memwrite_r <= ex_memwrite;
      memtoreg_r <= ex_memtoreg;
      regwrite_r <= ex_regwrite && (ex_rg != 5'd0);
    end
  end

  // Data memory write port; contents survive reset, only the write itself is blocked.
  always_ff @(posedge clk) begin
    if (!rst && !freeze && memwrite_r) begin
      mem_array_r[addr_s] <= data_r;
    end
  end

  // MEM/WB pipeline register; the read word is the pre-write value on a same-edge store.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_data_r     <= 32'd0;
      wb_rg_r       <= 5'd0;
      wb_regwrite_r <= 1'b0;
    end else if (!freeze) begin
      wb_data_r     <= memtoreg_r ? rdata_s : alures_r;
      wb_rg_r       <= rg_r;
      wb_regwrite_r <= regwrite_r;
    end
  end

  assign mem_alures   = alures_r;
  assign mem_rg       = rg_r;
  assign mem_regwrite = regwrite_r;
  assign wb_data      = wb_data_r;
  assign wb_rg        = wb_rg_r;
  assign wb_regwrite  = wb_regwrite_r;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: an instruction-level model predicts the six outputs
// after every edge; a negedge monitor pops and compares. Directed checks use constants.
module tb_mem_stage;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, freeze;
  logic [31:0] ex_alures, ex_data;
  logic [4:0]  ex_rg;
  logic        ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg;
  logic [31:0] mem_alures, wb_data;
  logic [4:0]  mem_rg, wb_rg;
  logic        mem_regwrite, wb_regwrite;

  mem_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .ex_alures(ex_alures), .ex_data(ex_data), .ex_rg(ex_rg),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .mem_alures(mem_alures), .mem_rg(mem_rg), .mem_regwrite(mem_regwrite),
    .wb_data(wb_data), .wb_rg(wb_rg), .wb_regwrite(wb_regwrite)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alures;
    logic [31:0] data;
    logic [4:0]  rg;
    logic        wr;
    logic        rw;
    logic        m2r;
  } ins_t;

  typedef struct {
    logic [31:0] ma;
    logic [4:0]  mr;
    logic        mw;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic        ww;
  } exp_t;

  exp_t        q[$];
  ins_t        in_mem;          // instruction currently doing its memory access
  logic [31:0] mdl [DEPTH];     // reference data memory
  logic [31:0] res_data;
  logic [4:0]  res_rg;
  logic        res_rw;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, queue the prediction.
  task automatic step(input logic r, input logic f, input logic [31:0] a, input logic [31:0] d,
                      input logic [4:0] g, input logic rd, input logic wr, input logic rw,
                      input logic m2r);
    int idx;
    logic [31:0] old;
    exp_t e;
    rst = r; freeze = f; ex_alures = a; ex_data = d; ex_rg = g;
    ex_memread = rd; ex_memwrite = wr; ex_regwrite = rw; ex_memtoreg = m2r;
    @(posedge clk);
    if (r) begin
      in_mem   = '{32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0};
      res_data = 32'd0; res_rg = 5'd0; res_rw = 1'b0;
    end else if (!f) begin
      idx = int'((in_mem.alures / 32'd4) % DEPTH);
      old = mdl[idx];
      if (in_mem.wr) mdl[idx] = in_mem.data;
      res_data = in_mem.m2r ? old : in_mem.alures;
      res_rg   = in_mem.rg;
      res_rw   = in_mem.rw && (in_mem.rg != 5'd0);
      in_mem   = '{a, d, g, wr, rw, m2r};
    end
    e.ma = in_mem.alures; e.mr = in_mem.rg; e.mw = in_mem.rw && (in_mem.rg != 5'd0);
    e.wd = res_data; e.wr = res_rg; e.ww = res_rw;
    q.push_back(e);
    #1;
  endtask

  task automatic nop();
    step(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare every output against the prediction queued for the last edge.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("mem_alures", mem_alures, e.ma);
      chk("mem_rg", {27'd0, mem_rg}, {27'd0, e.mr});
      chk("mem_regwrite", {31'd0, mem_regwrite}, {31'd0, e.mw});
      chk("wb_data", wb_data, e.wd);
      chk("wb_rg", {27'd0, wb_rg}, {27'd0, e.wr});
      chk("wb_regwrite", {31'd0, wb_regwrite}, {31'd0, e.ww});
    end
  end

  initial begin
    logic [31:0] v;
    logic [31:0] old30;
    in_mem = '{32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0};
    res_data = 32'd0; res_rg = 5'd0; res_rw = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));
    chk("rst_mem_alures", mem_alures, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_regwrite", {31'd0, wb_regwrite}, 32'd0);

    // Fill every word so later loads are fully predictable
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'b0, 32'(4 * i), $urandom, 5'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);

    // Store then load
    step(1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h10, 32'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
    nop();
    chk("ld_wb_data", wb_data, 32'hDEADBEEF);
    chk("ld_wb_rg", {27'd0, wb_rg}, 32'd8);
    chk("ld_wb_regwrite", {31'd0, wb_regwrite}, 32'd1);

    // ALU pass-through
    step(1'b0, 1'b0, 32'h12345678, 32'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("alu_mem_alures", mem_alures, 32'h12345678);
    nop();
    chk("alu_wb_data", wb_data, 32'h12345678);

    // Register 0 never writes
    step(1'b0, 1'b0, $urandom, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("r0_mem_regwrite", {31'd0, mem_regwrite}, 32'd0);
    nop();
    chk("r0_wb_regwrite", {31'd0, wb_regwrite}, 32'd0);

    // Address wrap
    v = $urandom;
    step(1'b0, 1'b0, 32'(4 * DEPTH + 8), v, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'd8, 32'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
    nop();
    chk("wrap_wb_data", wb_data, v);

    // Freeze during a store
    v = $urandom;
    step(1'b0, 1'b0, 32'h20, v, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom));
    nop();
    step(1'b0, 1'b0, 32'h20, 32'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
    nop();
    chk("frz_wb_data", wb_data, v);

    // Reset while a store is in flight
    step(1'b0, 1'b0, 32'h30, $urandom, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0);
    old30 = mdl[(32'h30 / 4) % DEPTH];
    step(1'b1, 1'b0, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
         1'($urandom), 1'($urandom));
    nop();
    chk("rstmid_mem_regwrite", {31'd0, mem_regwrite}, 32'd0);
    chk("rstmid_wb_regwrite", {31'd0, wb_regwrite}, 32'd0);
    step(1'b0, 1'b0, 32'h30, 32'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
    nop();
    chk("rstmid_wb_data", wb_data, old30);

    // Random traffic over a window three times the memory size
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
           32'($urandom_range(0, 12 * DEPTH - 1)), $urandom, 5'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    nop();
    nop();

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
